rob_retire: RTL

- In-order reorder buffer and retire stage. It sits directly upstream of the architectural register file write ports.
- Allocates one entry per cycle at dispatch and accepts up to two functional-unit completions per cycle.
- Retires up to two completed head entries per cycle onto the register file's dual write port (shared write enable, physical address 0 = no write).
- Releases the retiring instructions' previous physical registers to the free list.

---
 rtl/rob_retire_pkg.sv | 20 ++
 rtl/rob_entry_array.sv | 57 +++++
 rtl/rob_retire.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rob_retire_pkg.sv
// Shared constants and types for the reorder buffer / retire stage.
// Optional RETIRE_COUNT_EN adds a retired-instruction counter on rob_retire.
package rob_retire_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX   = 4;
  localparam int AR_SIZE   = 6;

  typedef logic [ROB_IDX-1:0] rob_idx_t;

  typedef struct packed {
    logic               valid;
    logic               done;
    logic [AR_SIZE-1:0] pdest;
    logic [5:0]         areg;
    logic [AR_SIZE-1:0] old_pdest;
    logic [31:0]        data;
  } rob_entry_t;

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: one allocate port, two completion ports,
// two head read ports that double as retire-clear ports.
module rob_entry_array
  import rob_retire_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_en,
  input  rob_idx_t   alloc_idx,
  input  rob_entry_t alloc_entry,
  input  logic       cmp_en1,
  input  rob_idx_t   cmp_idx1,
  input  logic [31:0] cmp_data1,
  input  logic       cmp_en2,
  input  rob_idx_t   cmp_idx2,
  input  logic [31:0] cmp_data2,
  input  logic       clr_en1,
  input  logic       clr_en2,
  input  rob_idx_t   rd_idx1,
  input  rob_idx_t   rd_idx2,
  output rob_entry_t rd_entry1,
  output rob_entry_t rd_entry2
);

  rob_entry_t mem [ROB_DEPTH];

  assign rd_entry1 = mem[rd_idx1];
  assign rd_entry2 = mem[rd_idx2];

  // Later writes win: port 1 over port 2, allocation over a retiring head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (clr_en1) begin
        mem[rd_idx1].valid <= 1'b0;
        mem[rd_idx1].done  <= 1'b0;
      end
      if (clr_en2) begin
        mem[rd_idx2].valid <= 1'b0;
        mem[rd_idx2].done  <= 1'b0;
      end
      if (cmp_en2 && mem[cmp_idx2].valid) begin
        mem[cmp_idx2].done <= 1'b1;
        mem[cmp_idx2].data <= cmp_data2;
      end
      if (cmp_en1 && mem[cmp_idx1].valid) begin
        mem[cmp_idx1].done <= 1'b1;
        mem[cmp_idx1].data <= cmp_data1;
      end
      if (alloc_en)
        mem[alloc_idx] <= alloc_entry;
    end
  end

endmodule

// File: rtl/rob_retire.sv
// In-order ROB with dual retire onto the register file write ports.
// Define RETIRE_COUNT_EN to add the retired_count performance counter.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  output logic               alloc_ready,
  input  logic [AR_SIZE-1:0] alloc_pdest,
  input  logic [5:0]         alloc_areg,
  input  logic [AR_SIZE-1:0] alloc_old_pdest,
  output logic [ROB_IDX-1:0] alloc_idx,
  input  logic               cmp_valid1,
  input  logic               cmp_valid2,
  input  logic [ROB_IDX-1:0] cmp_idx1,
  input  logic [ROB_IDX-1:0] cmp_idx2,
  input  logic [31:0]        cmp_data1,
  input  logic [31:0]        cmp_data2,
  output logic [AR_SIZE-1:0] write_addr1,
  output logic [AR_SIZE-1:0] write_addr2,
  output logic [31:0]        write_data1,
  output logic [31:0]        write_data2,
  output logic [5:0]         old_addr1,
  output logic [5:0]         old_addr2,
  output logic               write_en,
  output logic               free_valid1,
  output logic               free_valid2,
  output logic [AR_SIZE-1:0] free_preg1,
  output logic [AR_SIZE-1:0] free_preg2,
  output logic               rob_empty,
  output logic [ROB_IDX:0]   rob_count
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0]        retired_count
`endif
);

  rob_idx_t       head;
  rob_idx_t       tail;
  logic [ROB_IDX:0] count;
  rob_idx_t       head_nx;
  rob_entry_t     hd1;
  rob_entry_t     hd2;
  rob_entry_t     new_entry;
  logic           r0;
  logic           r1;
  logic           alloc_fire;
  logic [1:0]     nret;
  logic           fv1;
  logic           fv2;

  assign head_nx     = head + rob_idx_t'(1);
  assign alloc_ready = ~count[ROB_IDX];
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_idx   = tail;
  assign rob_empty   = (count == '0);
  assign rob_count   = count;

  assign r0   = hd1.valid & hd1.done;
  assign r1   = r0 & hd2.valid & hd2.done;
  assign nret = {1'b0, r0} + {1'b0, r1};

  assign fv1 = r0 & (|hd1.pdest) & (|hd1.old_pdest);
  assign fv2 = r1 & (|hd2.pdest) & (|hd2.old_pdest);

  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.pdest     = alloc_pdest;
    new_entry.areg      = alloc_areg;
    new_entry.old_pdest = alloc_old_pdest;
  end

  rob_entry_array u_array (
    .clk         (clk),
    .rst         (rst),
    .alloc_en    (alloc_fire),
    .alloc_idx   (tail),
    .alloc_entry (new_entry),
    .cmp_en1     (cmp_valid1),
    .cmp_idx1    (cmp_idx1),
    .cmp_data1   (cmp_data1),
    .cmp_en2     (cmp_valid2),
    .cmp_idx2    (cmp_idx2),
    .cmp_data2   (cmp_data2),
    .clr_en1     (r0),
    .clr_en2     (r1),
    .rd_idx1     (head),
    .rd_idx2     (head_nx),
    .rd_entry1   (hd1),
    .rd_entry2   (hd2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + {{(ROB_IDX-2){1'b0}}, nret};
      tail  <= tail + {{(ROB_IDX-1){1'b0}}, alloc_fire};
      count <= count + {{ROB_IDX{1'b0}}, alloc_fire}
                     - {{(ROB_IDX-1){1'b0}}, nret};
    end
  end

  // Retire outputs lag the decision by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en    <= 1'b0;
      write_addr1 <= '0;
      write_addr2 <= '0;
      write_data1 <= '0;
      write_data2 <= '0;
      old_addr1   <= '0;
      old_addr2   <= '0;
      free_valid1 <= 1'b0;
      free_valid2 <= 1'b0;
      free_preg1  <= '0;
      free_preg2  <= '0;
    end else begin
      write_en    <= r0;
      write_addr1 <= r0 ? hd1.pdest : '0;
      write_addr2 <= r1 ? hd2.pdest : '0;
      write_data1 <= r0 ? hd1.data : '0;
      write_data2 <= r1 ? hd2.data : '0;
      old_addr1   <= r0 ? hd1.areg : '0;
      old_addr2   <= r1 ? hd2.areg : '0;
      free_valid1 <= fv1;
      free_valid2 <= fv2;
      free_preg1  <= fv1 ? hd1.old_pdest : '0;
      free_preg2  <= fv2 ? hd2.old_pdest : '0;
    end
  end

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      retired_count <= '0;
    else
      retired_count <= retired_count + {30'd0, nret};
  end
`endif

endmodule
